// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART RX controller and the rest of the receive path:
// frame configuration going in, deserializer controls and status coming out.
interface uart_rx_ctrl_if;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       sampled_bit;
  logic       deser_en;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  modport master (
    input  par_en, par_typ, prescale,
    output sampled_bit, deser_en, edge_count, bit_count,
           data_valid, par_err, stp_err
  );

  modport slave (
    output par_en, par_typ, prescale,
    input  sampled_bit, deser_en, edge_count, bit_count,
           data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line synchronizer, start detection, per-bit edge
// timing, 2-of-3 majority sampling and start/parity/stop checking.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, counters held at 0, waiting for a low line
// START  | start bit; a high sample at bit end is a glitch -> IDLE
// DATA   | data bits 1..DATA_WIDTH, deserializer enabled
// PARITY | parity bit, compared against running XOR at bit end
// STOP   | stop bit, a low sample flags a stop error
// DONE   | single cycle, data_valid pulses for a clean frame
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx_in,
  uart_rx_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       rx_s_q, rx_s_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [2:0] samp_q, samp_d;
  logic       sampled_q, sampled_d;
  logic       par_acc_q, par_acc_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;
  logic       dv_q, dv_d;
  logic       deser_en_q, deser_en_d;

  logic [5:0] half;
  logic [5:0] last;
  logic       bit_end;

  assign half    = {1'b0, bus.prescale[5:1]};
  assign last    = bus.prescale - 6'd1;
  assign bit_end = (edge_q == last);

  // Next-state, counter, sampling and flag logic.
  always_comb begin
    state_d    = state_q;
    sync1_d    = rx_in;
    rx_s_d     = sync1_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    samp_d     = samp_q;
    sampled_d  = sampled_q;
    par_acc_d  = par_acc_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;

    if (state_q != S_IDLE) begin
      if (bit_end) begin
        edge_d = 6'd0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 6'd1;
      end
      if (edge_q == half - 6'd2) samp_d[0] = rx_s_q;
      if (edge_q == half - 6'd1) samp_d[1] = rx_s_q;
      if (edge_q == half)        samp_d[2] = rx_s_q;
      if (edge_q == half + 6'd1)
        sampled_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                    (samp_q[1] & samp_q[2]);
    end

    case (state_q)
      S_IDLE: begin
        edge_d = 6'd0;
        bit_d  = 4'd0;
        if (!rx_s_q) begin
          state_d   = S_START;
          par_acc_d = 1'b0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          if (!sampled_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
            edge_d  = 6'd0;
            bit_d   = 4'd0;
          end
        end
      end
      S_DATA: begin
        if (bit_end) begin
          par_acc_d = par_acc_q ^ sampled_q;
          if (bit_q == 4'(DATA_WIDTH))
            state_d = bus.par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_err_d = (sampled_q != (par_acc_q ^ bus.par_typ));
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          stp_err_d = ~sampled_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        edge_d  = 6'd0;
        bit_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = 6'd0;
        bit_d   = 4'd0;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    deser_en_d = (state_d == S_DATA);
    dv_d       = (state_q == S_STOP) && (state_d == S_DONE) &&
                 !par_err_d && !stp_err_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      edge_q     <= 6'd0;
      bit_q      <= 4'd0;
      samp_q     <= 3'b111;
      sampled_q  <= 1'b1;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      deser_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      sampled_q  <= sampled_d;
      par_acc_q  <= par_acc_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      dv_q       <= dv_d;
      deser_en_q <= deser_en_d;
    end
  end

  assign bus.sampled_bit = sampled_q;
  assign bus.deser_en    = deser_en_q;
  assign bus.edge_count  = edge_q;
  assign bus.bit_count   = bit_q;
  assign bus.data_valid  = dv_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames from the test plan plus randomized
// frames checked against a frame-level expectation model.
module tb_uart_rx_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;

  uart_rx_ctrl_if bus_if();

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int dv_cyc = 0;
  int de_rise_cnt = 0;
  int de_rise_cyc = 0;
  int de_fall_cyc = 0;
  logic [DW-1:0] deser = '0;
  logic [DW-1:0] dv_data = '0;
  logic de_prev = 1'b0;

  // Deserializer stand-in and event recorder, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (bus_if.deser_en && bus_if.edge_count == bus_if.prescale - 6'd1)
      deser = {bus_if.sampled_bit, deser[DW-1:1]};
    if (rst_n && bus_if.data_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_data = deser;
    end
    if (bus_if.deser_en && !de_prev) begin
      de_rise_cnt++;
      de_rise_cyc = cyc;
    end
    if (!bus_if.deser_en && de_prev) de_fall_cyc = cyc;
    de_prev = bus_if.deser_en;
  end

  // Drives one frame starting at the current falling edge; g_bit/g_off select a
  // single inverted cycle (g_bit < 0 for none).
  task automatic send_frame(input logic [DW-1:0] d, input bit bad_par, input bit stop_v,
                            input int g_bit, input int g_off, output int fall);
    int p;
    int nb;
    logic [11:0] bits;
    p = int'(bus_if.prescale);
    bits = '0;
    for (int i = 0; i < DW; i++) bits[1+i] = d[i];
    nb = DW + 1;
    if (bus_if.par_en) begin
      bits[nb] = (^d) ^ bus_if.par_typ ^ bad_par;
      nb = nb + 1;
    end
    bits[nb] = stop_v;
    nb = nb + 1;
    fall = cyc;
    for (int b = 0; b < nb; b++)
      for (int o = 0; o < p; o++) begin
        rx_in = (b == g_bit && o == g_off) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    rx_in = 1'b1;
  endtask

  task automatic set_cfg(input int p, input bit pe, input bit pt);
    bus_if.prescale = 6'(p);
    bus_if.par_en = pe;
    bus_if.par_typ = pt;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus_if.sampled_bit, bus_if.deser_en, bus_if.edge_count, bus_if.bit_count,
         bus_if.data_valid, bus_if.par_err, bus_if.stp_err} !== {1'b1, 1'b0, 6'd0, 4'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_values got sb=%b de=%b ec=%0d bc=%0d dv=%b pe=%b se=%b exp 1 0 0 0 0 0 0",
               bus_if.sampled_bit, bus_if.deser_en, bus_if.edge_count, bus_if.bit_count,
               bus_if.data_valid, bus_if.par_err, bus_if.stp_err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clean_even();
    int fall, n0;
    set_cfg(8, 1, 0);
    n0 = dv_cnt;
    send_frame(8'hA5, 0, 1, -1, 0, fall);
    repeat (5) @(negedge clk);
    total++; if (dv_cnt - n0 !== 1) begin bad++; $display("FAIL clean_dv_count got=%0d exp=1", dv_cnt - n0); end
    total++; if (dv_cyc - fall !== 3 + 88) begin bad++; $display("FAIL clean_dv_latency got=%0d exp=%0d", dv_cyc - fall, 91); end
    total++; if (dv_data !== 8'hA5) begin bad++; $display("FAIL clean_data got=%h exp=a5", dv_data); end
    total++; if ({bus_if.par_err, bus_if.stp_err} !== 2'b00) begin bad++; $display("FAIL clean_flags got=%b%b exp=00", bus_if.par_err, bus_if.stp_err); end
    total++; if (de_rise_cyc - fall !== 3 + 8) begin bad++; $display("FAIL clean_deser_rise got=%0d exp=11", de_rise_cyc - fall); end
    total++; if (de_fall_cyc - fall !== 3 + 72) begin bad++; $display("FAIL clean_deser_fall got=%0d exp=75", de_fall_cyc - fall); end
  endtask

  task automatic test_parity_err();
    int fall, n0;
    set_cfg(8, 1, 1);
    n0 = dv_cnt;
    send_frame(8'hA5, 1, 1, -1, 0, fall);
    repeat (5) @(negedge clk);
    total++; if (bus_if.par_err !== 1'b1) begin bad++; $display("FAIL par_err_set got=%b exp=1", bus_if.par_err); end
    total++; if (bus_if.stp_err !== 1'b0) begin bad++; $display("FAIL par_err_stp got=%b exp=0", bus_if.stp_err); end
    total++; if (dv_cnt - n0 !== 0) begin bad++; $display("FAIL par_err_no_dv got=%0d exp=0", dv_cnt - n0); end
    n0 = dv_cnt;
    send_frame(8'hA5, 0, 1, -1, 0, fall);
    repeat (5) @(negedge clk);
    total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL par_err_cleared got=%b exp=0", bus_if.par_err); end
    total++; if (dv_cnt - n0 !== 1) begin bad++; $display("FAIL odd_clean_dv got=%0d exp=1", dv_cnt - n0); end
    total++; if (dv_data !== 8'hA5) begin bad++; $display("FAIL odd_clean_data got=%h exp=a5", dv_data); end
  endtask

  task automatic test_stop_err();
    int fall, n0;
    set_cfg(16, 0, 0);
    n0 = dv_cnt;
    send_frame(8'h3C, 0, 0, -1, 0, fall);
    repeat (5) @(negedge clk);
    total++; if (bus_if.stp_err !== 1'b1) begin bad++; $display("FAIL stp_err_set got=%b exp=1", bus_if.stp_err); end
    total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL stp_err_par got=%b exp=0", bus_if.par_err); end
    total++; if (dv_cnt - n0 !== 0) begin bad++; $display("FAIL stp_err_no_dv got=%0d exp=0", dv_cnt - n0); end
    repeat (3) @(negedge clk);
    total++; if ({bus_if.edge_count, bus_if.bit_count} !== 10'd0) begin bad++; $display("FAIL stp_err_idle got ec=%0d bc=%0d exp 0 0", bus_if.edge_count, bus_if.bit_count); end
  endtask

  task automatic test_start_glitch();
    int n0, r0;
    set_cfg(8, 1, 0);
    n0 = dv_cnt;
    r0 = de_rise_cnt;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (7) @(negedge clk);
    total++; if (bus_if.edge_count !== 6'd7) begin bad++; $display("FAIL glitch_start_end got ec=%0d exp=7", bus_if.edge_count); end
    @(negedge clk);
    total++; if ({bus_if.edge_count, bus_if.bit_count} !== 10'd0) begin bad++; $display("FAIL glitch_to_idle got ec=%0d bc=%0d exp 0 0", bus_if.edge_count, bus_if.bit_count); end
    repeat (3) @(negedge clk);
    total++; if (bus_if.edge_count !== 6'd0) begin bad++; $display("FAIL glitch_held got ec=%0d exp=0", bus_if.edge_count); end
    total++; if (de_rise_cnt - r0 !== 0) begin bad++; $display("FAIL glitch_deser_en got rises=%0d exp=0", de_rise_cnt - r0); end
    total++; if ({bus_if.par_err, bus_if.stp_err} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b%b exp=00", bus_if.par_err, bus_if.stp_err); end
    total++; if (dv_cnt - n0 !== 0) begin bad++; $display("FAIL glitch_no_dv got=%0d exp=0", dv_cnt - n0); end
  endtask

  task automatic test_majority();
    int fall, n0;
    set_cfg(32, 1, 0);
    n0 = dv_cnt;
    send_frame(8'h55, 0, 1, 4, 16, fall);
    repeat (5) @(negedge clk);
    total++; if (dv_cnt - n0 !== 1) begin bad++; $display("FAIL majority_dv got=%0d exp=1", dv_cnt - n0); end
    total++; if (dv_data !== 8'h55) begin bad++; $display("FAIL majority_data got=%h exp=55", dv_data); end
    total++; if (bus_if.par_err !== 1'b0) begin bad++; $display("FAIL majority_par got=%b exp=0", bus_if.par_err); end
  endtask

  task automatic test_reset_mid();
    int fall, n0;
    logic [DW-1:0] d;
    set_cfg(8, 0, 0);
    n0 = dv_cnt;
    d = 8'h3C;
    for (int b = 0; b < 5; b++) begin
      rx_in = (b == 0) ? 1'b0 : d[b-1];
      repeat (8) @(negedge clk);
    end
    rx_in = d[4];
    repeat (4) @(negedge clk);
    total++; if (bus_if.deser_en !== 1'b1) begin bad++; $display("FAIL mid_in_data got de=%b exp=1", bus_if.deser_en); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus_if.sampled_bit, bus_if.deser_en, bus_if.edge_count, bus_if.bit_count,
         bus_if.data_valid, bus_if.par_err, bus_if.stp_err} !== {1'b1, 1'b0, 6'd0, 4'd0, 3'b000}) begin
      bad++;
      $display("FAIL mid_reset_values got sb=%b de=%b ec=%0d bc=%0d dv=%b pe=%b se=%b exp 1 0 0 0 0 0 0",
               bus_if.sampled_bit, bus_if.deser_en, bus_if.edge_count, bus_if.bit_count,
               bus_if.data_valid, bus_if.par_err, bus_if.stp_err);
    end
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    total++; if (dv_cnt - n0 !== 0) begin bad++; $display("FAIL mid_no_partial_dv got=%0d exp=0", dv_cnt - n0); end
    send_frame(8'h81, 0, 1, -1, 0, fall);
    repeat (5) @(negedge clk);
    total++; if (dv_cnt - n0 !== 1) begin bad++; $display("FAIL post_reset_dv got=%0d exp=1", dv_cnt - n0); end
    total++; if (dv_data !== 8'h81) begin bad++; $display("FAIL post_reset_data got=%h exp=81", dv_data); end
    total++; if (dv_cyc - fall !== 3 + 80) begin bad++; $display("FAIL post_reset_latency got=%0d exp=83", dv_cyc - fall); end
  endtask

  task automatic test_random();
    int fall, n0, p, g_bit, exp_len;
    bit pe, pt, bad_par, stop_v, exp_pe, exp_se, exp_dv;
    logic [DW-1:0] d;
    for (int k = 0; k < 24; k++) begin
      p = 8 << $urandom_range(0, 2);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      d = DW'($urandom);
      bad_par = pe && ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 3) != 0);
      g_bit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DW)) : -1;
      set_cfg(p, pe, pt);
      exp_pe = bad_par;
      exp_se = !stop_v;
      exp_dv = !exp_pe && !exp_se;
      exp_len = 3 + (DW + 2 + int'(pe)) * p;
      n0 = dv_cnt;
      send_frame(d, bad_par, stop_v, g_bit, p / 2, fall);
      repeat (5) @(negedge clk);
      total++; if (dv_cnt - n0 !== int'(exp_dv)) begin bad++; $display("FAIL rand%0d_dv got=%0d exp=%0d", k, dv_cnt - n0, exp_dv); end
      if (exp_dv) begin
        total++; if (dv_data !== d) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", k, dv_data, d); end
        total++; if (dv_cyc - fall !== exp_len) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", k, dv_cyc - fall, exp_len); end
      end
      total++; if (bus_if.par_err !== exp_pe) begin bad++; $display("FAIL rand%0d_par_err got=%b exp=%b", k, bus_if.par_err, exp_pe); end
      total++; if (bus_if.stp_err !== exp_se) begin bad++; $display("FAIL rand%0d_stp_err got=%b exp=%b", k, bus_if.stp_err, exp_se); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    set_cfg(8, 0, 0);
    @(negedge clk);
    test_reset();
    test_clean_even();
    test_parity_err();
    test_stop_err();
    test_start_glitch();
    test_majority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
